router_pkt_fifo: RTL and testbench
==================================

Name: router_pkt_fifo

Overview:
Parametrised packet-aware FIFO for one output channel of the router. It is the next generation of the per-port FIFO: configurable data width and depth, and a correct extra-bit full/empty scheme. Each stored word carries a header marker, and the read side tracks the remaining bytes of the current packet. It adds occupancy, almost-full and sticky error flags. It sits between the router's input FSM/register stage (write side) and the destination port read interface.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, number of entries; must be a power of two, >= 4
AW, log2(DEPTH), pointer index width (derived localparam, not overridable)
LEN_LSB, 2, LSB position of the payload-length field within a header word
LEN_W, 6, width of the payload-length field (LEN_LSB+LEN_W <= DATA_W)
AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-low reset
sft_rst  input  1  synchronous soft reset (timeout flush), active-high
we  input  1  write enable
din  input  DATA_W  write data
lfd_state  input  1  high in the cycle the header is loaded upstream; marks the NEXT accepted write as a header
rd_en  input  1  read enable
dout  output  DATA_W  registered read data
dout_valid  output  1  dout holds a word popped on the previous edge
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
almost_full  output  1  fill_level >= DEPTH-AF_MARGIN
fill_level  output  AW+1  current occupancy 0..DEPTH
pkt_remaining  output  LEN_W+1  bytes of current packet still to be read (payload+parity)
sof_out  output  1  word on dout is a header (valid with dout_valid)
ovf_err  output  1  sticky: write attempted while full
unf_err  output  1  sticky: read attempted while empty

Behaviour:
- Reset: rst is synchronous and active-low, on clock clk. rst low at a clock edge sets all outputs and state to zero: pointers, fill_level, pkt_remaining, dout=0, dout_valid=0, sof_out=0, errors=0, lfd delay flop=0. Memory contents are not reset. rst has priority over sft_rst.
- Soft reset: sft_rst=1 at an edge clears pointers, fill_level, pkt_remaining, dout_valid, sof_out, ovf_err and unf_err; dout<=0. Any we/rd_en in the same cycle is ignored. Outputs never go to Z.
- Storage: each entry is DATA_W+1 bits: {hdr, data}. lfd_state passes through one register stage (lfd_d); a write accepted while lfd_d=1 stores hdr=1, otherwise hdr=0.
- Pointers: wr_ptr and rd_ptr are AW+1 bits and wrap naturally. empty = (wr_ptr==rd_ptr). full = (MSBs differ && lower AW bits equal). Both are combinational from registered pointers.
- Write: accepted when we && !full; stores at wr_ptr[AW-1:0], then wr_ptr+1. we && full: data dropped, pointers unchanged, ovf_err<=1.
- Read: accepted when rd_en && !empty. Next edge: dout<=mem data, sof_out<=hdr, dout_valid<=1, rd_ptr+1. Read latency is 1 cycle. With no accepted read: dout holds its value and dout_valid<=0. rd_en && empty: unf_err<=1, no pointer change.
- Simultaneous read and write: full and empty are evaluated before the edge. When full, only the read is accepted (level DEPTH-1). When empty, only the write is accepted (level 1). Otherwise both are accepted and fill_level is unchanged.
- fill_level: +1 on write only, -1 on read only, unchanged otherwise.
- pkt_remaining: on an accepted read of a hdr=1 word, loads data[LEN_LSB+:LEN_W]+1, zero-extended to LEN_W+1 bits. On an accepted read of a hdr=0 word, decrements if nonzero and saturates at 0.
- Errors stay set until rst or sft_rst.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release -> empty=1, full=0, fill_level=0, dout=0, dout_valid=0, all errors 0.
- Fill/drain with wrap: DEPTH=16; write 16 words 0x01..0x10 -> full=1, almost_full set from level 14. A 17th write -> ovf_err=1 and data dropped. Read 16 words -> dout 0x01..0x10 in order, each 1 cycle after rd_en. Repeat twice to exercise pointer wrap.
- Packet tracking: pulse lfd_state, then write header 0x14 (len=5) followed by 6 bytes. Read -> sof_out=1 with header, pkt_remaining=6, then 5,4,...,0 after each byte.
- Simultaneous rd/wr: at level 16, assert we and rd_en -> read only, level 15. At level 0, assert both -> write only, level 1, dout_valid=0. At level 7, assert both -> level stays 7.
- Soft reset mid-packet: at level 9 with pkt_remaining=4, pulse sft_rst with we=1 -> empty=1, level=0, pkt_remaining=0, errors cleared, write ignored.
- Underflow: rd_en while empty -> unf_err=1 and stays set. rst=0 clears it.

Source files
------------

// File: rtl/router_pkt_fifo_if.sv
// Write/read bus of the per-port packet FIFO.
// master: upstream input FSM and destination port reader (drives we/din/lfd_state/rd_en).
// slave : the FIFO (drives read data, status and error flags).
interface router_pkt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 6
);
  localparam int AW = $clog2(DEPTH);

  logic              we;
  logic [DATA_W-1:0] din;
  logic              lfd_state;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [AW:0]       fill_level;
  logic [LEN_W:0]    pkt_remaining;
  logic              sof_out;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output we, din, lfd_state, rd_en,
    input  dout, dout_valid, full, empty, almost_full, fill_level,
           pkt_remaining, sof_out, ovf_err, unf_err
  );

  modport slave (
    input  we, din, lfd_state, rd_en,
    output dout, dout_valid, full, empty, almost_full, fill_level,
           pkt_remaining, sof_out, ovf_err, unf_err
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO: stores {hdr,data}, tracks bytes left in the packet being read.
// Latency: a read accepted at an edge presents dout/sof_out/dout_valid after that edge (1 cycle).
// Backpressure: writes while full are dropped (ovf_err), reads while empty ignored (unf_err); full/empty gate acceptance.
// Ports: clk, rst (sync active-low), sft_rst (sync active-high flush), bus (slave side of router_pkt_fifo_if).
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int LEN_LSB   = 2,
  parameter int LEN_W     = 6,
  parameter int AF_MARGIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sft_rst,
  router_pkt_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [LEN_W:0] REM_ONE  = (LEN_W+1)'(1);

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, fill_level;
  logic [LEN_W:0]    pkt_remaining;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, sof_out, ovf_err, unf_err, lfd_d;

  logic              full, empty, wr_acc, rd_acc;
  logic [DATA_W:0]   rd_word;
  logic [LEN_W-1:0]  hdr_len;

  // Extra pointer bit distinguishes full (laps differ) from empty (same lap).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_acc  = bus.we && !full;
  assign rd_acc  = bus.rd_en && !empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign hdr_len = rd_word[LEN_LSB +: LEN_W];

  // Storage is not reset; a flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (rst && !sft_rst && wr_acc)
      mem[wr_ptr[AW-1:0]] <= {lfd_d, bus.din};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_level    <= '0;
      pkt_remaining <= '0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      sof_out       <= 1'b0;
      ovf_err       <= 1'b0;
      unf_err       <= 1'b0;
      lfd_d         <= 1'b0;
    end else begin
      // lfd_state is raised the cycle before the header word arrives.
      lfd_d <= bus.lfd_state;
      if (sft_rst) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        fill_level    <= '0;
        pkt_remaining <= '0;
        dout          <= '0;
        dout_valid    <= 1'b0;
        sof_out       <= 1'b0;
        ovf_err       <= 1'b0;
        unf_err       <= 1'b0;
      end else begin
        if (wr_acc)
          wr_ptr <= wr_ptr + PTR_ONE;

        if (rd_acc) begin
          rd_ptr     <= rd_ptr + PTR_ONE;
          dout       <= rd_word[DATA_W-1:0];
          sof_out    <= rd_word[DATA_W];
          dout_valid <= 1'b1;
          // Header length counts payload only; +1 covers the trailing parity byte.
          if (rd_word[DATA_W])
            pkt_remaining <= {1'b0, hdr_len} + REM_ONE;
          else if (pkt_remaining != '0)
            pkt_remaining <= pkt_remaining - REM_ONE;
        end else begin
          dout_valid <= 1'b0;
        end

        case ({wr_acc, rd_acc})
          2'b10:   fill_level <= fill_level + PTR_ONE;
          2'b01:   fill_level <= fill_level - PTR_ONE;
          default: fill_level <= fill_level;
        endcase

        if (bus.we && full)
          ovf_err <= 1'b1;
        if (bus.rd_en && empty)
          unf_err <= 1'b1;
      end
    end
  end

  assign bus.dout          = dout;
  assign bus.dout_valid    = dout_valid;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.almost_full   = (fill_level >= AF_LEVEL);
  assign bus.fill_level    = fill_level;
  assign bus.pkt_remaining = pkt_remaining;
  assign bus.sof_out       = sof_out;
  assign bus.ovf_err       = ovf_err;
  assign bus.unf_err       = unf_err;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: read expectations are queued when a read is issued
// and a negedge monitor pops and compares whenever dout_valid is seen.
module tb_router_pkt_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sft_rst = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       sof;
    logic [6:0] pkt;
    logic [7:0] dat;
  } rd_exp_t;

  rd_exp_t exp_q[$];

  router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16), .LEN_W(6)) bus();

  router_pkt_fifo #(
    .DATA_W(8), .DEPTH(16), .LEN_LSB(2), .LEN_W(6), .AF_MARGIN(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sft_rst (sft_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read got %0h want none", bus.dout);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        chk("rd_dout", 32'(bus.dout), 32'(e.dat));
        chk("rd_sof", 32'(bus.sof_out), 32'(e.sof));
        chk("rd_pkt_remaining", 32'(bus.pkt_remaining), 32'(e.pkt));
      end
    end
  end

  // One clock: drive inputs, take the edge, return to idle 1 time unit later.
  task automatic cyc(input logic w, input logic [7:0] d, input logic l, input logic r, input logic s);
    bus.we        = w;
    bus.din       = d;
    bus.lfd_state = l;
    bus.rd_en     = r;
    sft_rst       = s;
    @(posedge clk);
    #1;
    bus.we        = 1'b0;
    bus.din       = 8'h00;
    bus.lfd_state = 1'b0;
    bus.rd_en     = 1'b0;
    sft_rst       = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic sof, input logic [7:0] d, input logic [6:0] pkt);
    exp_q.push_back('{sof: sof, pkt: pkt, dat: d});
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.we = 1'b0; bus.din = 8'h00; bus.lfd_state = 1'b0; bus.rd_en = 1'b0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_fill", 32'(bus.fill_level), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_dout_valid", 32'(bus.dout_valid), 0);
    chk("rst_ovf", 32'(bus.ovf_err), 0);
    chk("rst_unf", 32'(bus.unf_err), 0);
    chk("rst_pkt", 32'(bus.pkt_remaining), 0);
    chk("rst_af", 32'(bus.almost_full), 0);

    // Fill/drain twice: second pass wraps both pointers through the extra bit.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        wr(8'(i + 1));
        chk("fill_level_up", 32'(bus.fill_level), 32'(i + 1));
        chk("almost_full", 32'(bus.almost_full), 32'((i + 1) >= 14));
        chk("full_flag", 32'(bus.full), 32'(i == 15));
      end
      wr(8'h55);
      chk("ovf_err_set", 32'(bus.ovf_err), 1);
      chk("ovf_level_kept", 32'(bus.fill_level), 16);
      for (int i = 0; i < 16; i++) begin
        rd(1'b0, 8'(i + 1), 7'd0);
        chk("fill_level_down", 32'(bus.fill_level), 32'(15 - i));
      end
      chk("drained_empty", 32'(bus.empty), 1);
      idle();
      chk("dout_valid_drop", 32'(bus.dout_valid), 0);
      chk("dout_hold", 32'(bus.dout), 32'h10);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("sft_clears_ovf", 32'(bus.ovf_err), 0);

    // Packet: header 0x14 -> len field 5 -> 6 bytes to follow.
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    wr(8'h14);
    for (int i = 0; i < 6; i++) wr(8'(8'hA0 + i));
    chk("pkt_fill", 32'(bus.fill_level), 7);
    rd(1'b1, 8'h14, 7'd6);
    for (int i = 0; i < 6; i++) rd(1'b0, 8'(8'hA0 + i), 7'(5 - i));
    idle();
    chk("pkt_done", 32'(bus.pkt_remaining), 0);

    // Simultaneous read/write at full: only the read goes through.
    for (int i = 0; i < 16; i++) wr(8'(8'h30 + i));
    chk("sim_full_pre", 32'(bus.full), 1);
    exp_q.push_back('{sof: 1'b0, pkt: 7'd0, dat: 8'h30});
    cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("sim_full_level", 32'(bus.fill_level), 15);
    chk("sim_full_flag", 32'(bus.full), 0);
    for (int i = 1; i < 16; i++) rd(1'b0, 8'(8'h30 + i), 7'd0);
    chk("sim_full_drained", 32'(bus.empty), 1);

    // At empty: only the write goes through, no word is presented.
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("sim_empty_level", 32'(bus.fill_level), 1);
    chk("sim_empty_dout_valid", 32'(bus.dout_valid), 0);
    chk("sim_empty_unf", 32'(bus.unf_err), 1);

    // Mid level: both accepted, occupancy unchanged.
    for (int i = 0; i < 6; i++) wr(8'(8'h78 + i));
    chk("sim_mid_pre", 32'(bus.fill_level), 7);
    exp_q.push_back('{sof: 1'b0, pkt: 7'd0, dat: 8'h77});
    cyc(1'b1, 8'h7E, 1'b0, 1'b1, 1'b0);
    chk("sim_mid_level", 32'(bus.fill_level), 7);
    for (int i = 0; i < 7; i++) rd(1'b0, 8'(8'h78 + i), 7'd0);
    chk("sim_mid_drained", 32'(bus.empty), 1);

    // Soft reset mid-packet at level 9, pkt_remaining 4, with a write in the same cycle.
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    wr(8'h14);
    for (int i = 0; i < 11; i++) wr(8'(8'hB0 + i));
    rd(1'b1, 8'h14, 7'd6);
    rd(1'b0, 8'hB0, 7'd5);
    rd(1'b0, 8'hB1, 7'd4);
    chk("sft_pre_level", 32'(bus.fill_level), 9);
    chk("sft_pre_pkt", 32'(bus.pkt_remaining), 4);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("sft_empty", 32'(bus.empty), 1);
    chk("sft_level", 32'(bus.fill_level), 0);
    chk("sft_pkt", 32'(bus.pkt_remaining), 0);
    chk("sft_unf", 32'(bus.unf_err), 0);
    chk("sft_ovf", 32'(bus.ovf_err), 0);
    chk("sft_dout", 32'(bus.dout), 0);
    chk("sft_dout_valid", 32'(bus.dout_valid), 0);
    idle();
    chk("sft_write_ignored", 32'(bus.fill_level), 0);

    // Underflow is sticky until rst.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("unf_set", 32'(bus.unf_err), 1);
    chk("unf_level", 32'(bus.fill_level), 0);
    idle();
    chk("unf_sticky", 32'(bus.unf_err), 1);
    rst = 1'b0;
    idle();
    rst = 1'b1;
    chk("unf_rst_clear", 32'(bus.unf_err), 0);

    idle();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
